// File: rtl/i2s_capture_sequencer.sv
`timescale 1ns/1ps
// i2s_capture_sequencer
//   Sequences the I2S mic receiver (reset + start-up wait) and writes blocks
//   of stereo samples {left,right} into the capture BRAM.
//   Optional feature macro: CAPTURE_TRIGGER_EN (adds a level-triggered ARM
//   state between an accepted start and the capture itself).
module i2s_capture_sequencer #(
  parameter int ADDR_WIDTH     = 12,
  parameter int WARMUP_CYCLES  = 1_000_000,
  parameter int TRIG_THRESHOLD = 2048
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  enable_in,
  input  logic                  start_in,
  input  logic [ADDR_WIDTH-1:0] length_in,
  input  logic                  new_sample_in,
  input  logic [15:0]           left_sample_in,
  input  logic [15:0]           right_sample_in,
  output logic                  rx_reset_out,
  output logic                  wr_en_out,
  output logic [ADDR_WIDTH-1:0] wr_addr_out,
  output logic [31:0]           wr_data_out,
  output logic                  ready_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  abort_out
);

  localparam int CW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;

  // ST_FINISH is the one-cycle slot after the last write in which done is raised
  typedef enum logic [2:0] {
    ST_OFF,
    ST_WARMUP,
    ST_IDLE,
    ST_CAPTURE,
    ST_FINISH,
    ST_ARM
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         warm_cnt_q, warm_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]           wr_data_q, wr_data_d;
  logic                  done_q, done_d;
  logic                  abort_q, abort_d;
  logic                  busy;

`ifdef CAPTURE_TRIGGER_EN
  // Magnitude taken at 17 bits so that -32768 maps to +32768
  function automatic logic over_threshold(input logic [15:0] s);
    logic [16:0] ext;
    logic [16:0] mag;
    ext = {s[15], s};
    mag = s[15] ? (17'd0 - ext) : ext;
    return (mag >= 17'(TRIG_THRESHOLD));
  endfunction
`endif

  assign busy = (state_q == ST_CAPTURE) || (state_q == ST_FINISH) || (state_q == ST_ARM);

  // Next-state and registered-output computation
  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    addr_d     = addr_q;
    len_d      = len_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;
    abort_d    = 1'b0;

    if (!enable_in) begin
      // Dropping enable overrides everything, including a same-cycle strobe
      state_d    = ST_OFF;
      warm_cnt_d = '0;
      abort_d    = busy;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d    = ST_WARMUP;
          warm_cnt_d = '0;
        end
        ST_WARMUP: begin
          if (warm_cnt_q == CW'(WARMUP_CYCLES - 1)) state_d = ST_IDLE;
          else warm_cnt_d = warm_cnt_q + 1'b1;
        end
        ST_IDLE: begin
          if (start_in) begin
            len_d  = length_in;
            addr_d = '0;
`ifdef CAPTURE_TRIGGER_EN
            state_d = ST_ARM;
`else
            state_d = ST_CAPTURE;
`endif
          end
        end
`ifdef CAPTURE_TRIGGER_EN
        ST_ARM: begin
          if (new_sample_in &&
              (over_threshold(left_sample_in) || over_threshold(right_sample_in))) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = {left_sample_in, right_sample_in};
            if (addr_q == len_q) state_d = ST_FINISH;
            else begin
              addr_d  = addr_q + 1'b1;
              state_d = ST_CAPTURE;
            end
          end
        end
`endif
        ST_CAPTURE: begin
          if (new_sample_in) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = {left_sample_in, right_sample_in};
            if (addr_q == len_q) state_d = ST_FINISH;
            else addr_d = addr_q + 1'b1;
          end
        end
        ST_FINISH: begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q    <= ST_OFF;
      warm_cnt_q <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
    end
  end

  assign rx_reset_out = (state_q == ST_OFF);
  assign ready_out    = (state_q == ST_IDLE);
  assign busy_out     = busy;
  assign wr_en_out    = wr_en_q;
  assign wr_addr_out  = wr_addr_q;
  assign wr_data_out  = wr_data_q;
  assign done_out     = done_q;
  assign abort_out    = abort_q;

endmodule

// File: tb/tb_i2s_capture_sequencer.sv
`timescale 1ns/1ps
// Testbench for i2s_capture_sequencer: directed stimulus, cycle-level
// behavioural model with per-cycle comparison, plus literal spot checks.
module tb_i2s_capture_sequencer;

  localparam int AW = 12;
  localparam int WARM = 16;
  localparam int TH = 2048;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] length = '0;
  logic          ns = 1'b0;
  logic [15:0]   left = '0;
  logic [15:0]   right = '0;
  logic          rx_reset_out, wr_en_out, ready_out, busy_out, done_out, abort_out;
  logic [AW-1:0] wr_addr_out;
  logic [31:0]   wr_data_out;

  int checks = 0;
  int errors = 0;

  i2s_capture_sequencer #(
    .ADDR_WIDTH(AW),
    .WARMUP_CYCLES(WARM),
    .TRIG_THRESHOLD(TH)
  ) dut (
    .clock_in(clk),
    .reset_in(rst),
    .enable_in(en),
    .start_in(start),
    .length_in(length),
    .new_sample_in(ns),
    .left_sample_in(left),
    .right_sample_in(right),
    .rx_reset_out(rx_reset_out),
    .wr_en_out(wr_en_out),
    .wr_addr_out(wr_addr_out),
    .wr_data_out(wr_data_out),
    .ready_out(ready_out),
    .busy_out(busy_out),
    .done_out(done_out),
    .abort_out(abort_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_on = 0;       // mics powered (receiver out of reset)
  int          m_elapsed = 0;  // cycles spent powered, saturating at WARM
  bit          m_cap = 0;      // collecting samples
  bit          m_arm = 0;      // waiting for a loud sample
  bit          m_fin = 0;      // last write issued, done owed next cycle
  int          m_next = 0;     // address the next accepted sample goes to
  int          m_len = 0;      // index of the final sample of the block
  logic        e_wr = 0, e_done = 0, e_abort = 0;
  logic [AW-1:0] e_addr = '0;
  logic [31:0] e_data = '0;

  // DUT observation log (written only by the compare process)
  logic [AW+31:0] wlog[$];
  int n_done = 0;
  int n_abort = 0;

  function automatic int mag16(input logic [15:0] s);
    int v;
    v = int'($signed(s));
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_write(input int a);
    e_wr   = 1;
    e_addr = AW'(a);
    e_data = {left, right};
    if (a == m_len) begin
      m_cap = 0;
      m_arm = 0;
      m_fin = 1;
    end else begin
      m_cap  = 1;
      m_arm  = 0;
      m_next = a + 1;
    end
  endtask

  // Advance the model on each edge, then compare the DUT just after it
  always @(posedge clk) begin
    e_wr = 0; e_done = 0; e_abort = 0;
    if (rst) begin
      m_on = 0; m_elapsed = 0; m_cap = 0; m_arm = 0; m_fin = 0;
    end else if (!en) begin
      e_abort = m_cap || m_arm || m_fin;
      m_on = 0; m_elapsed = 0; m_cap = 0; m_arm = 0; m_fin = 0;
    end else if (!m_on) begin
      m_on = 1;
      m_elapsed = 0;
    end else if (m_elapsed < WARM) begin
      m_elapsed++;
    end else if (m_fin) begin
      e_done = 1;
      m_fin = 0;
    end else if (m_cap) begin
      if (ns) model_write(m_next);
    end else if (m_arm) begin
      if (ns && (mag16(left) >= TH || mag16(right) >= TH)) model_write(0);
    end else if (start) begin
      m_len = int'(length);
      m_next = 0;
`ifdef CAPTURE_TRIGGER_EN
      m_arm = 1;
`else
      m_cap = 1;
`endif
    end
    #1;
    chk("rx_reset", rx_reset_out, !m_on);
    chk("ready", ready_out, m_on && m_elapsed == WARM && !(m_cap || m_arm || m_fin));
    chk("busy", busy_out, m_cap || m_arm || m_fin);
    chk("wr_en", wr_en_out, e_wr);
    chk("done", done_out, e_done);
    chk("abort", abort_out, e_abort);
    if (e_wr) begin
      chk("wr_addr", wr_addr_out, e_addr);
      chk("wr_data", wr_data_out, e_data);
    end
    if (wr_en_out) wlog.push_back({wr_addr_out, wr_data_out});
    if (done_out) n_done++;
    if (abort_out) n_abort++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [15:0] l, input logic [15:0] r);
    ns = 1; left = l; right = r;
    @(negedge clk);
    ns = 0;
    @(negedge clk);
  endtask

  task automatic start_cap(input logic [AW-1:0] len);
    start = 1; length = len;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (ready_out !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_reached", ready_out, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, w0, d0, a0;
    logic [15:0] l16;
    cyc(3);
    chk("reset_rx", rx_reset_out, 1'b1);
    chk("reset_wr", wr_en_out, 1'b0);
    rst = 0;
    cyc(2);
    chk("off_rx", rx_reset_out, 1'b1);

    // 1: warmup timing, strobes ignored during warmup
    w0 = wlog.size();
    en = 1;
    strobe(16'h1234, 16'h5678);
    strobe(16'h1234, 16'h5678);
    strobe(16'h1234, 16'h5678);
    wait_ready(n);
    chk("warm_cycles", n + 6, 17);
    chk("warm_no_write", wlog.size() - w0, 0);

    // 2: four-sample block
    w0 = wlog.size(); d0 = n_done;
    start_cap(12'd3);
    for (int k = 1; k <= 4; k++) begin
      l16 = 16'(16'h1111 * k);
      strobe(l16, 16'(-k));
    end
    cyc(2);
    chk("blk_writes", wlog.size() - w0, 4);
    chk("blk_w0", wlog[w0 + 0], {12'd0, 32'h1111FFFF});
    chk("blk_w1", wlog[w0 + 1], {12'd1, 32'h2222FFFE});
    chk("blk_w2", wlog[w0 + 2], {12'd2, 32'h3333FFFD});
    chk("blk_w3", wlog[w0 + 3], {12'd3, 32'h4444FFFC});
    chk("blk_done", n_done - d0, 1);

    // 3: abort after two writes (with a same-cycle strobe), then re-warm
    w0 = wlog.size(); d0 = n_done; a0 = n_abort;
    start_cap(12'd3);
    strobe(16'h0AAA, 16'h0BBB);
    strobe(16'h0CCC, 16'h0DDD);
    en = 0; ns = 1; left = 16'h7777; right = 16'h7777;
    @(negedge clk);
    ns = 0;
    cyc(3);
    chk("abort_pulses", n_abort - a0, 1);
    chk("abort_no_done", n_done - d0, 0);
    chk("abort_writes", wlog.size() - w0, 2);
    chk("abort_rx", rx_reset_out, 1'b1);
    en = 1;
    wait_ready(n);
    chk("rewarm_cycles", n, 17);

`ifndef CAPTURE_TRIGGER_EN
    // 4: strobe concurrent with start is dropped; start during capture ignored
    w0 = wlog.size(); d0 = n_done;
    start = 1; length = 12'd1; ns = 1; left = 16'hAAAA; right = 16'h5555;
    @(negedge clk);
    start = 0; ns = 0;
    @(negedge clk);
    strobe(16'h0001, 16'h0002);
    start_cap(12'd7);
    strobe(16'h0003, 16'h0004);
    cyc(2);
    chk("start_strobe_w0", wlog[w0], {12'd0, 32'h00010002});
    chk("start_ignored_writes", wlog.size() - w0, 2);
    chk("start_ignored_done", n_done - d0, 1);

    // reset mid-capture: no done or abort
    d0 = n_done; a0 = n_abort;
    start_cap(12'd5);
    strobe(16'h0101, 16'h0202);
    rst = 1;
    cyc(2);
    rst = 0;
    cyc(1);
    chk("rst_no_done", n_done - d0, 0);
    chk("rst_no_abort", n_abort - a0, 0);
    wait_ready(n);

    // 5: full-depth block
    w0 = wlog.size(); d0 = n_done;
    start_cap('1);
    for (int k = 0; k < 4096; k++) strobe(16'(k), 16'(~k));
    cyc(2);
    chk("full_writes", wlog.size() - w0, 4096);
    chk("full_last_addr", wlog[wlog.size() - 1][AW+31:32], 12'd4095);
    chk("full_done", n_done - d0, 1);
`else
    // 6: level trigger
    w0 = wlog.size(); d0 = n_done;
    start_cap(12'd0);
    strobe(16'd100, 16'd0);
    strobe(16'hF801, 16'd0);
    strobe(16'hF800, 16'd0);
    cyc(2);
    chk("trig_writes", wlog.size() - w0, 1);
    chk("trig_w0", wlog[w0], {12'd0, 32'hF8000000});
    chk("trig_done", n_done - d0, 1);
    w0 = wlog.size();
    start_cap(12'd0);
    strobe(16'd5, 16'd7);
    strobe(16'h8000, 16'd0);
    cyc(2);
    chk("trig_min_w0", wlog[w0], {12'd0, 32'h80000000});
`endif

    cyc(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
